// File: rtl/jam_cost_arbiter_pkg.sv
// Shared widths and types for the jam cost-matrix arbiter.
package jam_pkg;
  localparam int COST_W = 7;
  localparam int IDX_W  = 3;

  typedef logic [COST_W-1:0] cost_t;
  typedef logic [IDX_W-1:0]  idx_t;

  typedef struct packed {
    logic valid;
    idx_t id;
  } arb_tag_t;
endpackage

// File: rtl/jam_cost_arbiter_if.sv
// Engine request/response bus plus the shared cost-memory read port.
interface jam_cost_arbiter_if #(parameter int N_REQ = 4);
  import jam_pkg::*;

  logic [N_REQ-1:0]       req;
  logic [IDX_W*N_REQ-1:0] req_w;
  logic [IDX_W*N_REQ-1:0] req_j;
  logic [N_REQ-1:0]       gnt;
  logic                   mem_re;
  idx_t                   mem_w;
  idx_t                   mem_j;
  cost_t                  mem_cost;
  logic [N_REQ-1:0]       rsp_valid;
  cost_t                  rsp_cost;

  modport master (
    output req, req_w, req_j, mem_cost,
    input  gnt, mem_re, mem_w, mem_j, rsp_valid, rsp_cost
  );

  modport slave (
    input  req, req_w, req_j, mem_cost,
    output gnt, mem_re, mem_w, mem_j, rsp_valid, rsp_cost
  );
endinterface

// File: rtl/jam_cost_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module jam_rr_pick
  import jam_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req_vec,
  input  idx_t             ptr,
  output logic [N_REQ-1:0] win_oh,
  output idx_t             win_idx,
  output logic             any
);

  always_comb begin
    int k;
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    k       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!any && req_vec[k]) begin
        any        = 1'b1;
        win_idx    = idx_t'(k);
        win_oh[k]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jam_cost_arbiter.sv
// Round-robin arbiter sharing one cost-matrix memory between N_REQ engines.
// Optional per-requester grant counters are built when JAM_ARB_STATS_EN is defined.
module jam_cost_arbiter
  import jam_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MEM_LAT = 1
) (
  input  logic CLK,
  input  logic RST,
  jam_cost_arbiter_if.slave bus
`ifdef JAM_ARB_STATS_EN
  ,
  input  logic [2:0]  stat_sel,
  output logic [15:0] stat_cnt
`endif
);

  logic [N_REQ-1:0] req_eff;
  logic [N_REQ-1:0] win_oh;
  idx_t             win_idx;
  logic             any;
  idx_t             ptr;
  idx_t             sel_w;
  idx_t             sel_j;
  arb_tag_t         tag_q [MEM_LAT];
  arb_tag_t         rsp_tag;
  logic [N_REQ-1:0] rsp_oh;

  // A requester holding req through its grant cycle is not granted back-to-back.
  assign req_eff = bus.req & ~bus.gnt;

  jam_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_vec (req_eff),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (any)
  );

  always_comb begin
    sel_w = '0;
    sel_j = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_oh[i]) begin
        sel_w = bus.req_w[i*IDX_W +: IDX_W];
        sel_j = bus.req_j[i*IDX_W +: IDX_W];
      end
    end
  end

  always_comb begin
    rsp_oh = '0;
    for (int i = 0; i < N_REQ; i++) rsp_oh[i] = (rsp_tag.id == idx_t'(i));
  end

  // Read data lands one cycle after the tag leaves the last stage, so rsp_tag
  // aligns the id with the memory's data window.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.gnt       <= '0;
      bus.mem_re    <= 1'b0;
      bus.mem_w     <= '0;
      bus.mem_j     <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_cost  <= '0;
      ptr           <= '0;
      rsp_tag       <= '0;
      for (int i = 0; i < MEM_LAT; i++) tag_q[i] <= '0;
    end else begin
      bus.gnt    <= win_oh;
      bus.mem_re <= any;
      if (any) begin
        bus.mem_w <= sel_w;
        bus.mem_j <= sel_j;
        ptr       <= (win_idx == idx_t'(N_REQ-1)) ? '0 : win_idx + idx_t'(1);
      end
      tag_q[0] <= {any, win_idx};
      for (int i = 1; i < MEM_LAT; i++) tag_q[i] <= tag_q[i-1];
      rsp_tag <= tag_q[MEM_LAT-1];
      if (rsp_tag.valid) begin
        bus.rsp_valid <= rsp_oh;
        bus.rsp_cost  <= bus.mem_cost;
      end else begin
        bus.rsp_valid <= '0;
      end
    end
  end

`ifdef JAM_ARB_STATS_EN
  logic [15:0] cnt_q [N_REQ];
  logic [15:0] stat_nxt;

  always_comb begin
    stat_nxt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (stat_sel == 3'(i)) stat_nxt = cnt_q[i];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_cnt <= '0;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      stat_cnt <= stat_nxt;
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.gnt[i] && (cnt_q[i] != 16'hFFFF)) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end
`endif

endmodule
